lsb_addr_alu_scheduler: RTL and testbench

//  Shares the single load/store address ALU between NREQ reservation-station issue

---
 rtl/lsb_addr_alu_scheduler_pkg.sv | 18 +
 rtl/lsb_addr_alu_scheduler_rr_arbiter.sv | 44 ++++
 rtl/lsb_addr_alu_scheduler.sv | 107 ++++++++++
 tb/tb_lsb_addr_alu_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_addr_alu_scheduler_pkg.sv
// Purpose: shared constants and helpers for the LSB address-ALU scheduler and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default slot count, queue depth, ROB id width (shared with RS/LSB/ROB), data width,
//   and a wrapping index increment used by round-robin pointers.
package lsb_addr_alu_scheduler_pkg;

   localparam int LSB_NREQ   = 4;
   localparam int LSB_QDEPTH = 2;
   localparam int LSB_ROB_W  = 5;
   localparam int LSB_XLEN   = 32;

   // Next index in a ring of n entries; n need not be a power of two.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/lsb_addr_alu_scheduler_rr_arbiter.sv
// Purpose: N-way round-robin arbiter; picks the first requester at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: en=0 suppresses the grant vector; idx still reports the would-be winner.
// Ports: req (N requests), ptr (priority start), en (grant enable),
//   grant (one-hot, gated by en), idx (binary index of the winner, 0 when none).
module rr_arbiter
   import lsb_addr_alu_scheduler_pkg::*;
#(
   parameter int N = LSB_NREQ
) (
   input  logic [N-1:0]          req,
   input  logic [$clog2(N)-1:0]  ptr,
   input  logic                  en,
   output logic [N-1:0]          grant,
   output logic [$clog2(N)-1:0]  idx
);

   localparam int PW = $clog2(N);

   always_comb begin
      int            j;
      logic [PW-1:0] jj;
      logic          found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      // Scan N positions starting at ptr; the first hit wins.
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         jj = PW'(j);
         if (!found && req[jj]) begin
            found     = 1'b1;
            idx       = jj;
            grant[jj] = en;
         end
      end
   end

endmodule

// File: rtl/lsb_addr_alu_scheduler.sv
// Purpose: shares one base+imm address ALU among NREQ RS issue slots and queues results for the LSB.
// Latency: result written to the queue at the grant edge; visible at the head the next cycle.
// Backpressure: lsb_full stalls the head; a full queue (registered count) blocks all grants.
// Ports: clk_in, rst_in (async active-low), rdy_in (global freeze), _clear (flush),
//   _req_valid/_req_rob_id/_req_base/_req_imm (per-slot requests), _req_grant (one-hot, comb),
//   _lsb_full (consumer stall), _out_ready/_out_rob_id/_out_value (queue head), _busy.
module lsb_addr_alu_scheduler
   import lsb_addr_alu_scheduler_pkg::*;
#(
   parameter int NREQ   = LSB_NREQ,
   parameter int QDEPTH = LSB_QDEPTH,
   parameter int ROB_W  = LSB_ROB_W,
   parameter int XLEN   = LSB_XLEN
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    _clear,
   input  logic [NREQ-1:0]         _req_valid,
   input  logic [NREQ*ROB_W-1:0]   _req_rob_id,
   input  logic [NREQ*XLEN-1:0]    _req_base,
   input  logic [NREQ*XLEN-1:0]    _req_imm,
   output logic [NREQ-1:0]         _req_grant,
   input  logic                    _lsb_full,
   output logic                    _out_ready,
   output logic [ROB_W-1:0]        _out_rob_id,
   output logic [XLEN-1:0]         _out_value,
   output logic                    _busy
);

   localparam int PW = $clog2(NREQ);
   localparam int QW = $clog2(QDEPTH);
   localparam int CW = QW + 1;

   logic [PW-1:0]    rr_ptr;
   logic [QW-1:0]    head;
   logic [QW-1:0]    tail;
   logic [CW-1:0]    count;
   logic [ROB_W-1:0] q_rob [QDEPTH];
   logic [XLEN-1:0]  q_val [QDEPTH];

   logic             accept;
   logic             pop;
   logic [PW-1:0]    grant_idx;
   logic [ROB_W-1:0] sel_rob;
   logic [XLEN-1:0]  sel_base;
   logic [XLEN-1:0]  sel_imm;
   logic [XLEN-1:0]  alu_value;

   // Space check uses the registered count only, so a pop in the same cycle
   // never lets a grant through. rst_in gates grants while reset is held.
   assign accept = rst_in & rdy_in & ~_clear & (count < CW'(QDEPTH)) & (|_req_valid);

   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (_req_valid),
      .ptr   (rr_ptr),
      .en    (accept),
      .grant (_req_grant),
      .idx   (grant_idx)
   );

   assign sel_rob   = _req_rob_id[grant_idx*ROB_W +: ROB_W];
   assign sel_base  = _req_base[grant_idx*XLEN +: XLEN];
   assign sel_imm   = _req_imm[grant_idx*XLEN +: XLEN];
   // Address arithmetic wraps modulo 2^XLEN; carry out is intentionally dropped.
   assign alu_value = sel_base + sel_imm;

   assign _out_ready  = (count != '0);
   assign _out_rob_id = q_rob[head];
   assign _out_value  = q_val[head];
   assign pop         = rst_in & rdy_in & ~_clear & _out_ready & ~_lsb_full;
   assign _busy       = _out_ready | (|_req_grant);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rr_ptr <= '0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_rob[i] <= '0;
            q_val[i] <= '0;
         end
      end else if (_clear) begin
         // Flush drops queued results; round-robin fairness state survives.
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy_in) begin
         if (accept) begin
            q_rob[tail] <= sel_rob;
            q_val[tail] <= alu_value;
            tail        <= tail + 1'b1;
            rr_ptr      <= PW'(wrap_inc(int'(grant_idx), NREQ));
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_lsb_addr_alu_scheduler.sv
// Purpose: self-checking bench for lsb_addr_alu_scheduler: directed scenarios plus random traffic
//   compared every cycle against a queue-based behavioural model.
// Latency/backpressure: exercised via lsb_full, rdy_in and _clear stimulus.
module tb_lsb_addr_alu_scheduler;

   localparam int NREQ   = 4;
   localparam int QDEPTH = 2;
   localparam int ROB_W  = 5;
   localparam int XLEN   = 32;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  rdy = 1'b1;
   logic                  clear = 1'b0;
   logic [NREQ-1:0]       valid = '0;
   logic [NREQ*ROB_W-1:0] rob_ids = '0;
   logic [NREQ*XLEN-1:0]  bases = '0;
   logic [NREQ*XLEN-1:0]  imms = '0;
   logic [NREQ-1:0]       grant;
   logic                  lsb_full = 1'b0;
   logic                  out_ready;
   logic [ROB_W-1:0]      out_rob;
   logic [XLEN-1:0]       out_val;
   logic                  busy;

   always #5 clk = ~clk;

   lsb_addr_alu_scheduler #(.NREQ(NREQ), .QDEPTH(QDEPTH), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
      .clk_in      (clk),
      .rst_in      (rst_n),
      .rdy_in      (rdy),
      ._clear      (clear),
      ._req_valid  (valid),
      ._req_rob_id (rob_ids),
      ._req_base   (bases),
      ._req_imm    (imms),
      ._req_grant  (grant),
      ._lsb_full   (lsb_full),
      ._out_ready  (out_ready),
      ._out_rob_id (out_rob),
      ._out_value  (out_val),
      ._busy       (busy)
   );

   typedef struct {
      logic [ROB_W-1:0] rob;
      logic [XLEN-1:0]  val;
   } ent_t;

   ent_t mq[$];
   int   mptr = 0;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO of results, fixed depth, fair pointer. Called at the negedge of each cycle
   // with the inputs that will be sampled at the next posedge.
   task automatic model_step();
      logic [NREQ-1:0] eg;
      int              g;
      bit              acc;
      bit              er;
      ent_t            e;
      eg  = '0;
      g   = -1;
      er  = (mq.size() > 0);
      acc = rdy && !clear && (mq.size() < QDEPTH) && (valid != 0);
      if (acc) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mptr + k) % NREQ;
            if (g < 0 && valid[i]) g = i;
         end
         eg[g] = 1'b1;
      end
      chk("grant", grant, eg);
      chk("out_ready", out_ready, er);
      chk("busy", busy, er || acc);
      if (er) begin
         chk("out_rob_id", out_rob, mq[0].rob);
         chk("out_value", out_val, mq[0].val);
      end
      if (clear) begin
         mq.delete();
      end else if (rdy) begin
         if (er && !lsb_full) void'(mq.pop_front());
         if (acc) begin
            e.rob = rob_ids[g*ROB_W +: ROB_W];
            e.val = bases[g*XLEN +: XLEN] + imms[g*XLEN +: XLEN];
            mq.push_back(e);
            mptr = (g + 1) % NREQ;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      if (rst_n) model_step();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset without waiting for an edge and checks outputs clear at once.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_out_ready", out_ready, 0);
      chk("rst_out_rob_id", out_rob, 0);
      chk("rst_out_value", out_val, 0);
      chk("rst_busy", busy, 0);
      mq.delete();
      mptr     = 0;
      valid    = '0;
      clear    = 1'b0;
      lsb_full = 1'b0;
      rdy      = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_slot(input int i, input logic [ROB_W-1:0] r, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] im);
      valid[i]                = 1'b1;
      rob_ids[i*ROB_W +: ROB_W] = r;
      bases[i*XLEN +: XLEN]     = b;
      imms[i*XLEN +: XLEN]      = im;
   endtask

   initial begin
      // 1: single request, negative offset
      do_reset();
      set_slot(2, 5'd9, 32'h0000_1000, 32'hFFFF_FFFC);
      #1 chk("t1_grant", grant, 4'b0100);
      cycle();
      valid = '0;
      #1;
      chk("t1_ready", out_ready, 1);
      chk("t1_rob", out_rob, 5'd9);
      chk("t1_value", out_val, 32'h0000_0FFC);
      cycle();
      cycle();

      // 2 and 4: fairness under lsb_full, full queue blocks grant even with a pop
      do_reset();
      for (int i = 0; i < NREQ; i++) set_slot(i, 5'(10 + i), 32'(i * 256), 32'd4);
      lsb_full = 1'b1;
      #1 chk("t2_grant0", grant, 4'b0001);
      cycle();
      chk("t2_grant1", grant, 4'b0010);
      cycle();
      chk("t2_full_grant", grant, 4'b0000);
      cycle();
      lsb_full = 1'b0;
      #1;
      chk("t4_pop_nogrant", grant, 4'b0000);
      chk("t2_head_rob", out_rob, 5'd10);
      cycle();
      chk("t4_grant_after", grant, 4'b0100);
      cycle();
      chk("t2_grant3", grant, 4'b1000);
      cycle();
      valid = '0;
      repeat (3) cycle();

      // 3: address wrap
      do_reset();
      set_slot(1, 5'd3, 32'hFFFF_FFF0, 32'h0000_0020);
      cycle();
      valid = '0;
      #1;
      chk("t3_value", out_val, 32'h0000_0010);
      chk("t3_rob", out_rob, 5'd3);
      cycle();

      // 5: clear with two queued entries and a pending request
      do_reset();
      for (int i = 0; i < NREQ; i++) set_slot(i, 5'(20 + i), 32'(i), 32'd1);
      lsb_full = 1'b1;
      cycle();
      cycle();
      clear = 1'b1;
      #1 chk("t5_grant", grant, 4'b0000);
      cycle();
      clear = 1'b0;
      #1;
      chk("t5_ready", out_ready, 0);
      chk("t5_ptr_kept", grant, 4'b0100);
      cycle();
      valid    = '0;
      lsb_full = 1'b0;
      repeat (2) cycle();

      // 6: rdy_in freeze, then asynchronous reset mid-run
      do_reset();
      set_slot(0, 5'd7, 32'h100, 32'h10);
      set_slot(1, 5'd8, 32'h200, 32'h20);
      lsb_full = 1'b1;
      cycle();
      cycle();
      valid    = '0;
      lsb_full = 1'b0;
      rdy      = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t6_frozen_ready", out_ready, 1);
         chk("t6_frozen_value", out_val, 32'h110);
         cycle();
      end
      rdy = 1'b1;
      cycle();
      valid = '1;
      #2;
      do_reset();

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            rob_ids[i*ROB_W +: ROB_W] = ROB_W'($urandom);
            bases[i*XLEN +: XLEN]     = $urandom;
            imms[i*XLEN +: XLEN]      = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 64));
         end
         lsb_full = ($urandom_range(0, 2) == 0);
         rdy      = ($urandom_range(0, 9) != 0);
         clear    = rdy && ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
